bcd_dabble_conv: RTL and testbench

BCD_DABBLE_CONV -- requirements
Module: bcd_dabble_conv

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd_dabble_conv.sv | 122 ++++++++++++
 tb/tb_bcd_dabble_conv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the double-dabble converter.
// Holds the FSM state type, add-3 constants and the digit-count check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_OFFSET = 4'd3;

    // True when DIGITS decimal digits can hold every DATA_W-bit value,
    // i.e. 10^digits > 2^data_w.
    function automatic bit bcd_dims_ok(input int data_w, input int digits);
        longint unsigned p10;
        longint unsigned p2;
        p10 = 1;
        p2  = 1;
        for (int i = 0; i < digits; i++) p10 = p10 * 10;
        for (int i = 0; i < data_w; i++) p2 = p2 * 2;
        return p10 > p2;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one-digit double-dabble correction (add 3 when >= 5).
// Ports: din - current BCD digit; dout - corrected digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) dout = din + ADD3_OFFSET;
    end

endmodule

// File: rtl/bcd_dabble_conv.sv
// bcd_dabble_conv: serial binary-to-BCD converter, one bit per clock.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data/in_ch
// sample side; out_valid/out_ready/out_bcd/out_sign/out_ch result side.
// Build macro BCD_SIGNED_EN: in_data is two's complement and out_sign
// reports negative samples; otherwise unsigned with out_sign = 0.
module bcd_dabble_conv
    import bcd_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5,
    parameter int CH_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [CH_W-1:0]       in_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_sign,
    output logic [CH_W-1:0]       out_ch
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    if (!bcd_dims_ok(DATA_W, DIGITS)) begin : g_bad_dims
        $error("bcd_dabble_conv: DIGITS too small for DATA_W");
    end

    bcd_state_t          state;
    bcd_state_t          state_next;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mag;
    logic [BCD_W-1:0]    digits;
    logic [BCD_W-1:0]    digits_adj;
    logic [BCD_W-1:0]    digits_next;
    logic [DATA_W-1:0]   mag_next;
    logic                sign_cap;
    logic [CH_W-1:0]     ch_cap;
    logic [DATA_W-1:0]   in_mag;
    logic                in_neg;
    logic                accept;
    logic                last_shift;

    always_comb begin
        in_mag = in_data;
        in_neg = 1'b0;
`ifdef BCD_SIGNED_EN
        if (in_data[DATA_W-1]) begin
            in_neg = 1'b1;
            in_mag = ~in_data + DATA_W'(1);
        end
`endif
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (digits[4*g +: 4]),
            .dout (digits_adj[4*g +: 4])
        );
    end

    // Corrected digits and magnitude shift left as one long register.
    assign {digits_next, mag_next} = {digits_adj, mag} << 1;

    assign accept     = (state == IDLE) && in_valid && in_ready;
    assign last_shift = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)     state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_sign  <= 1'b0;
            out_ch    <= '0;
            cnt       <= '0;
            digits    <= '0;
            mag       <= '0;
            sign_cap  <= 1'b0;
            ch_cap    <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (accept) begin
                mag      <= in_mag;
                sign_cap <= in_neg;
                ch_cap   <= in_ch;
                digits   <= '0;
                cnt      <= '0;
            end else if (state == SHIFT) begin
                digits <= digits_next;
                mag    <= mag_next;
                cnt    <= cnt + CNT_W'(1);
                if (last_shift) begin
                    out_bcd  <= digits_next;
                    out_sign <= sign_cap;
                    out_ch   <= ch_cap;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_dabble_conv.sv
// tb_bcd_dabble_conv: directed-vector bench for bcd_dabble_conv.
// Covers reset, latency, hold, mid-conversion reset and back-to-back.
module tb_bcd_dabble_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_sign;
    logic [2:0]  out_ch;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bcd_dabble_conv #(
        .DATA_W (16),
        .DIGITS (5),
        .CH_W   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_sign  (out_sign),
        .out_ch    (out_ch)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "/rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic convert(input string tag, input logic [15:0] d,
                           input logic [2:0] c, input logic [19:0] eb,
                           input logic es);
        int n;
        wait_ready(tag);
        in_data  = d;
        in_ch    = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "/busy"}, 32'(in_ready), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 40);
        chk({tag, "/lat"}, 32'(n), 32'd16);
        chk({tag, "/bcd"}, 32'(out_bcd), 32'(eb));
        chk({tag, "/sign"}, 32'(out_sign), 32'(es));
        chk({tag, "/ch"}, 32'(out_ch), 32'(c));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "/vclr"}, 32'(out_valid), 32'd0);
        chk({tag, "/rdy1"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ch     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst/in_ready", 32'(in_ready), 32'd0);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_bcd", 32'(out_bcd), 32'd0);
        chk("rst/out_sign", 32'(out_sign), 32'd0);
        chk("rst/out_ch", 32'(out_ch), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel/in_ready", 32'(in_ready), 32'd1);

        convert("v1234", 16'h1234, 3'd5, 20'h04660, 1'b0);
        convert("vzero", 16'h0000, 3'd1, 20'h00000, 1'b0);
        convert("v0063", 16'h0063, 3'd3, 20'h00099, 1'b0);
        convert("v270f", 16'h270F, 3'd4, 20'h09999, 1'b0);
        convert("v7fff", 16'h7FFF, 3'd6, 20'h32767, 1'b0);
`ifdef BCD_SIGNED_EN
        convert("v8000", 16'h8000, 3'd7, 20'h32768, 1'b1);
        convert("vffff", 16'hFFFF, 3'd2, 20'h00001, 1'b1);
        convert("vfff6", 16'hFFF6, 3'd0, 20'h00010, 1'b1);
`else
        convert("v8000", 16'h8000, 3'd7, 20'h32768, 1'b0);
        convert("vffff", 16'hFFFF, 3'd2, 20'h65535, 1'b0);
        convert("vfff6", 16'hFFF6, 3'd0, 20'h65526, 1'b0);
`endif

        // Result held in DONE while in_valid pulses must be ignored.
        wait_ready("hold");
        in_data  = 16'h04D2;
        in_ch    = 3'd6;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("hold/lat", 32'(n), 32'd16);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_data  = 16'(k * 321 + 7);
            in_ch    = 3'(k);
            tick();
            chk("hold/bcd", 32'(out_bcd), 32'h01234);
            chk("hold/ch", 32'(out_ch), 32'd6);
            chk("hold/valid", 32'(out_valid), 32'd1);
            chk("hold/in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold/vclr", 32'(out_valid), 32'd0);
        chk("hold/rdy", 32'(in_ready), 32'd1);
        tick();
        chk("hold/idle", 32'(in_ready), 32'd1);

        // Reset in the middle of a conversion drops it.
        wait_ready("mrst");
        in_data  = 16'h1234;
        in_ch    = 3'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst/rdy0", 32'(in_ready), 32'd0);
        chk("mrst/v0", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mrst/rdy1", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mrst/no_valid", 32'(seen), 32'd0);
        convert("mrst/v0063", 16'h0063, 3'd0, 20'h00099, 1'b0);

        // Back-to-back on channels 0..7 with out_ready held high.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    in_data  = 16'(i * 1111);
                    in_ch    = 3'(i);
                    in_valid = 1'b1;
                    n = 0;
                    while (!in_ready && n < 40) begin
                        tick();
                        n++;
                    end
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                int got;
                int last_cyc;
                logic [19:0] eb;
                got = 0;
                last_cyc = 0;
                for (int cyc = 0; cyc < 250 && got < 8; cyc++) begin
                    tick();
                    if (out_valid) begin
                        eb = {4'h0, 4'(got), 4'(got), 4'(got), 4'(got)};
                        chk("b2b/ch", 32'(out_ch), 32'(got));
                        chk("b2b/bcd", 32'(out_bcd), 32'(eb));
                        if (got > 0)
                            chk("b2b/gap", 32'(cyc - last_cyc), 32'd18);
                        last_cyc = cyc;
                        got++;
                    end
                end
                chk("b2b/count", 32'(got), 32'd8);
            end
        join
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
